i2c_master_arbiter: RTL and testbench
=====================================

Name: i2c_master_arbiter

Overview:
Shares one i2c master between NUM_REQ on-chip requesters, one single-byte transaction at a time. Arbitrates round-robin and latches the winner's rw/address/data. Starts the master, then waits for its completion, NACK or a timeout, and returns read data and status to the winner. Sits between the client logic and the i2c master's command interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 7, i2c slave address width
DATA_W, 8, data byte width
TIMEOUT, 1024, max cycles in WAIT before abort (>=2)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester transaction request, level
req_rw  in  NUM_REQ  per-requester direction, 1=read 0=write
req_addr  in  NUM_REQ*ADDR_W  per-requester slave address, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  per-requester write byte, same packing
gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
done  out  NUM_REQ  one-cycle pulse: transaction ACKed and completed
err  out  NUM_REQ  one-cycle pulse: NACK or timeout
rdata  out  DATA_W  read byte, valid with done, held until next read completes
busy  out  1  high in any state other than IDLE
m_start  out  1  start command to master
m_rw  out  1  latched direction
m_addr  out  ADDR_W  latched address
m_wdata  out  DATA_W  latched write byte
m_abort  out  1  one-cycle abort to master on timeout
m_busy  in  1  master executing a transaction
m_done  in  1  one-cycle pulse: master transaction finished
m_nack  in  1  valid with m_done: slave NACKed
m_rdata  in  DATA_W  valid with m_done

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, RR pointer=0. gnt, done, err, busy, m_abort, m_rw, m_addr, m_wdata and rdata all 0. m_start is 0.
- States: IDLE, LAUNCH, WAIT, FINISH. Register state and all outputs except m_start. m_start = (state==LAUNCH) && !m_busy.
- IDLE, any req set:
  - Winner = first set req scanning from the RR pointer upward, with wrap.
  - gnt <= onehot(winner).
  - Latch the winner's rw/addr/wdata into m_rw/m_addr/m_wdata.
  - Go to LAUNCH. gnt is visible the cycle after req is sampled.
- LAUNCH:
  - Stall while m_busy is high.
  - In the first cycle with m_busy low, m_start is high for exactly that cycle; next state is WAIT and the timeout counter is cleared.
- WAIT: the counter increments each cycle.
  - m_done with m_nack=0: done[winner] <= 1. If m_rw=1, rdata <= m_rdata.
  - m_done with m_nack=1: err[winner] <= 1. rdata is unchanged.
  - Counter reaches TIMEOUT-1 without m_done: err[winner] <= 1, m_abort <= 1. m_done arriving in that same cycle has priority over the timeout.
  - Any of the above: go to FINISH.
- FINISH (one cycle):
  - done/err/m_abort return to 0.
  - gnt returns to 0 at the end of the cycle.
  - RR pointer <= winner+1 mod NUM_REQ.
  - Go to IDLE.
- Requester rules:
  - Requester holds req and its inputs stable until its done/err.
  - The latched copy is authoritative: req or input changes after the grant have no effect, and the completion pulse is still issued.
  - The requester drops req in the cycle after done/err, or it is rearbitrated.
- Fairness: with all requesters requesting continuously, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- m_done outside WAIT is ignored.
- Minimum request-to-done latency is 4 cycles (IDLE sample, LAUNCH, WAIT with m_done, pulse visible). Back-to-back turnaround is FINISH plus IDLE, 2 cycles.
- At most one bit of gnt/done/err is ever high. done and err are never high together.

Test Plan:
- Reset then req=4'b0010, rw=0, addr=7'h50, wdata=8'hA6. Master model has m_busy=0 and returns m_done 5 cycles after m_start. Required:
  - gnt=4'b0010 one cycle after req.
  - m_start pulses once with m_addr=7'h50, m_wdata=8'hA6.
  - done[1] pulses once. rdata stays 0.
- req=4'b1111, all reads, model returns m_rdata=8'hF6 with no NACK. Required: grants 0,1,2,3,0 in order; each done pulse has rdata=8'hF6; no gnt overlap.
- Single request, model returns m_nack=1. Required: err pulses, done stays 0, rdata unchanged, busy back to 0 two cycles later.
- TIMEOUT=16 and the model never asserts m_done. Required: err[winner] and m_abort pulse exactly 16 cycles after m_start, then state returns to IDLE.
- m_busy held high 10 cycles after the grant. Required: m_start stays 0 for those 10 cycles, then pulses in the first cycle m_busy is low.
- rst driven low in WAIT. Required: all outputs read 0 immediately, without waiting for a clock edge. After release with req=4'b0001, requester 0 is granted and the RR pointer restarts from 0.

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one i2c master command port between NUM_REQ
// requesters, one single-byte transaction at a time, with a WAIT-state timeout.
module i2c_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      m_start,
  output logic                      m_rw,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  output logic                      m_abort,
  input  logic                      m_busy,
  input  logic                      m_done,
  input  logic                      m_nack,
  input  logic [DATA_W-1:0]         m_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

  // All FSM state lives in one struct so checkers can probe ctrl_q directly.
  typedef struct packed {
    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win;
    logic [CNT_W-1:0] cnt;
  } ctrl_t;

  ctrl_t ctrl_q, ctrl_d;

  logic [NUM_REQ-1:0] gnt_d, done_d, err_d;
  logic [DATA_W-1:0]  rdata_d, m_wdata_d;
  logic [ADDR_W-1:0]  m_addr_d;
  logic               busy_d, m_rw_d, m_abort_d;

  logic [PTR_W-1:0]   pick, cand;
  logic               found;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // First set request at or above the RR pointer, wrapping.
  always_comb begin
    pick  = ctrl_q.rr_ptr;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(ctrl_q.rr_ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Handshake: a requester holds req and its inputs until its one-cycle
  // done/err pulse; the grant-time latched copy drives the master, so later
  // input changes are ignored, and req must drop the cycle after the pulse.
  always_comb begin
    ctrl_d    = ctrl_q;
    gnt_d     = gnt;
    done_d    = '0;
    err_d     = '0;
    m_abort_d = 1'b0;
    rdata_d   = rdata;
    m_rw_d    = m_rw;
    m_addr_d  = m_addr;
    m_wdata_d = m_wdata;
    case (ctrl_q.state)
      IDLE: begin
        if (|req) begin
          ctrl_d.state = LAUNCH;
          ctrl_d.win   = pick;
          gnt_d        = '0;
          gnt_d[pick]  = 1'b1;
          m_rw_d       = req_rw[pick];
          m_addr_d     = addr_arr[pick];
          m_wdata_d    = wdata_arr[pick];
        end
      end
      LAUNCH: begin
        if (!m_busy) begin
          ctrl_d.state = WAIT;
          ctrl_d.cnt   = '0;
        end
      end
      WAIT: begin
        ctrl_d.cnt = ctrl_q.cnt + 1'b1;
        if (m_done) begin
          ctrl_d.state = FINISH;
          if (m_nack) begin
            err_d = gnt;
          end else begin
            done_d = gnt;
            if (m_rw) rdata_d = m_rdata;
          end
        end else if (ctrl_q.cnt == CNT_W'(TIMEOUT - 2)) begin
          // Counter reaches TIMEOUT-1 on this edge: abort the master.
          ctrl_d.state = FINISH;
          err_d        = gnt;
          m_abort_d    = 1'b1;
        end
      end
      FINISH: begin
        ctrl_d.state  = IDLE;
        gnt_d         = '0;
        ctrl_d.rr_ptr = (int'(ctrl_q.win) == NUM_REQ - 1) ? '0 : ctrl_q.win + 1'b1;
      end
      default: ctrl_d.state = IDLE;
    endcase
    busy_d = (ctrl_d.state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      m_rw    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_abort <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      gnt     <= gnt_d;
      done    <= done_d;
      err     <= err_d;
      rdata   <= rdata_d;
      busy    <= busy_d;
      m_rw    <= m_rw_d;
      m_addr  <= m_addr_d;
      m_wdata <= m_wdata_d;
      m_abort <= m_abort_d;
    end
  end

  assign m_start = (ctrl_q.state == LAUNCH) && !m_busy;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: randomized requesters and i2c master model,
// with a round-robin reference model feeding an expected-response scoreboard.
module tb_i2c_master_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int MAX_TX  = 4;
  localparam int MODE_OK = 0, MODE_NACK = 1, MODE_NEVER = 2;
  localparam int EW = 20;  // {latency[7:0], id[1:0], is_err, abort, rdata[7:0]}
  localparam int CW = 16;  // {rw, addr[6:0], wdata[7:0]}

  logic                      clk, rst;
  logic [NUM_REQ-1:0]        req, req_rw, gnt, done, err;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]         rdata, m_wdata, m_rdata;
  logic [ADDR_W-1:0]         m_addr;
  logic                      busy, m_start, m_rw, m_abort, m_busy, m_done, m_nack;

  i2c_master_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .busy(busy), .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_abort(m_abort), .m_busy(m_busy), .m_done(m_done),
    .m_nack(m_nack), .m_rdata(m_rdata)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [CW-1:0] exp_cmd_q[$];

  int mode = MODE_OK;
  int mlat = 5;
  logic [DATA_W-1:0] slave_mem [128];
  logic [DATA_W-1:0] ref_mem   [128];
  logic [DATA_W-1:0] ref_rdata;
  int ref_ptr;

  int                n_tx    [NUM_REQ];
  int                idx     [NUM_REQ];
  logic              tx_rw   [NUM_REQ][MAX_TX];
  logic [ADDR_W-1:0] tx_addr [NUM_REQ][MAX_TX];
  logic [DATA_W-1:0] tx_wd   [NUM_REQ][MAX_TX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic apply_tx(input int i, input int k);
    req_rw[i] = tx_rw[i][k];
    req_addr[i*ADDR_W +: ADDR_W] = tx_addr[i][k];
    req_wdata[i*DATA_W +: DATA_W] = tx_wd[i][k];
    req[i] = 1'b1;
  endtask

  task automatic clear_tx();
    for (int i = 0; i < NUM_REQ; i++) begin
      n_tx[i] = 0;
      idx[i]  = 0;
    end
  endtask

  task automatic set_tx(input int i, input int k, input logic rw,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    tx_rw[i][k] = rw;
    tx_addr[i][k] = a;
    tx_wd[i][k] = d;
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NUM_REQ; i++)
      if (idx[i] < n_tx[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_start", 32'(m_start), 32'd0);
    check("rst_m_rw", 32'(m_rw), 32'd0);
    check("rst_m_addr", 32'(m_addr), 32'd0);
    check("rst_m_wdata", 32'(m_wdata), 32'd0);
    check("rst_m_abort", 32'(m_abort), 32'd0);
    exp_q.delete();
    exp_cmd_q.delete();
    ref_ptr = 0;
    ref_rdata = '0;
    clear_tx();
    req = '0;
    req_rw = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Reference model: serve pending requests round-robin, one at a time,
  // recording the command each should launch and the response it should get.
  task automatic run_batch(input int busy_hold);
    int pend[NUM_REQ];
    int served[NUM_REQ];
    int ptr, w, s, first, total, budget;
    ptr = ref_ptr;
    first = -1;
    total = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = n_tx[i];
      served[i] = 0;
      total += n_tx[i];
    end
    for (int t = 0; t < total; t++) begin
      w = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
        if (pend[(ptr + k) % NUM_REQ] > 0) w = (ptr + k) % NUM_REQ;
      if (first < 0) first = w;
      s = served[w];
      if (mode == MODE_OK) begin
        if (tx_rw[w][s]) ref_rdata = ref_mem[tx_addr[w][s]];
        else ref_mem[tx_addr[w][s]] = tx_wd[w][s];
      end
      exp_cmd_q.push_back({tx_rw[w][s], tx_addr[w][s], tx_wd[w][s]});
      exp_q.push_back({8'((mode == MODE_NEVER) ? TIMEOUT : mlat + 1), 2'(w),
                       1'(mode != MODE_OK), 1'(mode == MODE_NEVER), ref_rdata});
      pend[w]--;
      served[w]++;
      ptr = (w + 1) % NUM_REQ;
    end
    ref_ptr = ptr;

    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx[i] = 0;
      if (n_tx[i] > 0) apply_tx(i, 0);
    end
    @(negedge clk);
    @(negedge clk);
    check("gnt_first", 32'(gnt), 32'(1 << first));
    if (busy_hold > 0) begin
      for (int k = 0; k < busy_hold; k++) begin
        if (k > 0) @(negedge clk);
        check("start_held_by_busy", 32'(m_start), 32'd0);
      end
      @(posedge clk);
      #1 m_busy = 1'b0;
      @(negedge clk);
      check("start_on_busy_low", 32'(m_start), 32'd1);
    end
    budget = 0;
    while (!all_done() && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (!all_done()) begin
      errors++;
      $display("FAIL batch_budget: batch incomplete after %0d cycles, %0d responses outstanding",
               budget, exp_q.size());
      clear_tx();
      req = '0;
    end
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_gnt", 32'(gnt), 32'd0);
    check("resp_queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_cmd_q.delete();
  endtask

  // Requesters: advance on their own completion pulse; while granted they
  // scramble req and inputs, which the arbiter must ignore.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (done[i] || err[i]) begin
          idx[i]++;
          if (idx[i] < n_tx[i]) apply_tx(i, idx[i]);
          else req[i] = 1'b0;
        end else if (gnt[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          req_rw[i] = 1'($urandom_range(0, 1));
          req_addr[i*ADDR_W +: ADDR_W] = 7'($urandom);
          req_wdata[i*DATA_W +: DATA_W] = 8'($urandom);
        end
      end
    end
  end

  // i2c master model with a slave memory behind it
  initial begin
    logic              c_rw;
    logic [ADDR_W-1:0] c_addr;
    int                c_lat, c_mode;
    m_done = 1'b0;
    m_nack = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && m_start && mode != MODE_NEVER) begin
        c_rw = m_rw;
        c_addr = m_addr;
        c_lat = mlat;
        c_mode = mode;
        if (c_mode == MODE_OK && !c_rw) slave_mem[c_addr] = m_wdata;
        @(posedge clk);
        repeat (c_lat - 1) @(posedge clk);
        #1;
        m_done = 1'b1;
        m_nack = (c_mode == MODE_NACK);
        m_rdata = (c_mode == MODE_OK && c_rw) ? slave_mem[c_addr] : 8'($urandom);
        @(posedge clk);
        #1;
        m_done = 1'b0;
        m_nack = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    logic [CW-1:0] c;
    logic [1:0]    id_act;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        check("pulse_onehot", 32'($countones({done, err}) <= 1), 32'd1);
        check("abort_with_err", 32'(m_abort && !(|err)), 32'd0);
        if (m_start) begin
          start_cyc = cyc;
          if (exp_cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: m_start with addr 0x%0h, none expected (cycle %0d)",
                     m_addr, cyc);
          end else begin
            c = exp_cmd_q.pop_front();
            check("cmd_latched", 32'({m_rw, m_addr, m_wdata}), 32'(c));
          end
        end
        if (|done || |err) begin
          id_act = '0;
          for (int i = 0; i < NUM_REQ; i++)
            if (done[i] || err[i]) id_act = 2'(i);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: done=%b err=%b, none expected (cycle %0d)",
                     done, err, cyc);
          end else begin
            e = exp_q.pop_front();
            check("resp_id", 32'(id_act), 32'(e[11:10]));
            check("resp_is_err", 32'(|err), 32'(e[9]));
            check("resp_abort", 32'(m_abort), 32'(e[8]));
            check("resp_rdata", 32'(rdata), 32'(e[7:0]));
            check("resp_latency", 32'(cyc - start_cyc), 32'(e[19:12]));
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b0;
    m_busy = 1'b0;
    req = '0;
    req_rw = '0;
    req_addr = '0;
    req_wdata = '0;
    for (int a = 0; a < 128; a++) begin
      slave_mem[a] = 8'hF6;
      ref_mem[a] = 8'hF6;
    end
    do_reset();

    // Single write from requester 1
    mode = MODE_OK;
    mlat = 5;
    clear_tx();
    n_tx[1] = 1;
    set_tx(1, 0, 1'b0, 7'h50, 8'hA6);
    run_batch(0);
    check("rdata_after_write", 32'(rdata), 32'd0);

    // All four read, requester 0 twice: expect 0,1,2,3,0
    do_reset();
    clear_tx();
    for (int i = 0; i < NUM_REQ; i++) begin
      n_tx[i] = 1;
      set_tx(i, 0, 1'b1, 7'(8'h10 + i), 8'h00);
    end
    n_tx[0] = 2;
    set_tx(0, 1, 1'b1, 7'h20, 8'h00);
    run_batch(0);

    // NACK
    mode = MODE_NACK;
    mlat = 3;
    clear_tx();
    n_tx[2] = 1;
    set_tx(2, 0, 1'b1, 7'h30, 8'h00);
    run_batch(0);

    // Master never completes
    mode = MODE_NEVER;
    clear_tx();
    n_tx[3] = 1;
    set_tx(3, 0, 1'b0, 7'h31, 8'h5A);
    run_batch(0);

    // Master busy for 10 cycles after the grant
    mode = MODE_OK;
    mlat = 2;
    clear_tx();
    n_tx[0] = 1;
    set_tx(0, 0, 1'b0, 7'h32, 8'h3C);
    m_busy = 1'b1;
    run_batch(10);

    // Randomized batches, each followed by a stray m_done while idle
    for (int b = 0; b < 20; b++) begin
      int r;
      clear_tx();
      r = int'($urandom_range(0, 9));
      mode = (r == 0) ? MODE_NEVER : ((r < 3) ? MODE_NACK : MODE_OK);
      mlat = int'($urandom_range(1, 6));
      for (int i = 0; i < NUM_REQ; i++) begin
        n_tx[i] = int'($urandom_range(0, 2));
        for (int k = 0; k < MAX_TX; k++)
          set_tx(i, k, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom));
      end
      if (n_tx[0] + n_tx[1] + n_tx[2] + n_tx[3] == 0) n_tx[int'($urandom_range(0, 3))] = 1;
      run_batch(0);
      @(posedge clk);
      #1;
      m_done = 1'b1;
      m_nack = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      m_done = 1'b0;
      m_nack = 1'b0;
      @(negedge clk);
      check("stray_done_ignored", 32'({busy, done, err}), 32'd0);
    end

    // Read to make rdata nonzero, then reset while in WAIT
    mode = MODE_OK;
    mlat = 2;
    clear_tx();
    n_tx[1] = 1;
    set_tx(1, 0, 1'b1, 7'h40, 8'h00);
    run_batch(0);
    mode = MODE_NEVER;
    clear_tx();
    n_tx[2] = 1;
    set_tx(2, 0, 1'b0, 7'h41, 8'h77);
    exp_cmd_q.push_back({1'b0, 7'h41, 8'h77});
    @(posedge clk);
    #1 apply_tx(2, 0);
    repeat (6) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    do_reset();

    // After reset requester 0 wins from a fresh pointer
    mode = MODE_OK;
    mlat = 1;
    clear_tx();
    n_tx[0] = 1;
    set_tx(0, 0, 1'b1, 7'h42, 8'h00);
    run_batch(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
